// File: rtl/ahb_addr_decoder_dphase.sv
// AHB 4-slave address decoder with data-phase select register and embedded
// default slave. Decodes HADDR to one-hot selects, registers the selected
// index for the read-data mux, and merges the default-slave response into
// the bus HREADY/HRESP.
module ahb_addr_decoder_dphase #(
  parameter logic [31:0] S1_BASE   = 32'h0000_0000,
  parameter logic [31:0] S2_BASE   = 32'h1000_0000,
  parameter logic [31:0] S3_BASE   = 32'h2000_0000,
  parameter logic [31:0] S4_BASE   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hF000_0000
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hready_mux_in,
  input  logic        hresp_mux_in,
  output logic        hsel1,
  output logic        hsel2,
  output logic        hsel3,
  output logic        hsel4,
  output logic [1:0]  mux_sel,
  output logic        dflt_dphase,
  output logic        hready,
  output logic        hresp
);

  localparam int NUM_SLV = 4;
  localparam logic [NUM_SLV-1:0][31:0] BASE = {S4_BASE, S3_BASE, S2_BASE, S1_BASE};

  typedef enum logic [1:0] {D_OK, D_ERR1, D_ERR2} dstate_t;

  logic [NUM_SLV-1:0] hit;
  logic [NUM_SLV-1:0] sel_oh;
  logic [1:0]         dec_idx;
  logic               mapped;
  logic               err_req;
  dstate_t            state, state_nxt;

  // Region compare per slave
  genvar g;
  generate
    for (g = 0; g < NUM_SLV; g++) begin : g_hit
      assign hit[g] = ((haddr & ADDR_MASK) == BASE[g]);
    end
  endgenerate

  // Priority resolve: lowest slave number wins on overlapping regions
  always_comb begin
    sel_oh  = '0;
    dec_idx = 2'd0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        dec_idx   = 2'(i);
      end
    end
  end

  assign mapped = |hit;
  assign {hsel4, hsel3, hsel2, hsel1} = sel_oh;

  // Active (NONSEQ/SEQ) transfer to an unmapped address being accepted
  assign err_req = hready && !mapped && htrans[1];

  // Data-phase owner register, advances only when the address phase is accepted
  always_ff @(posedge hclk) begin
    if (hreset) begin
      mux_sel     <= 2'b00;
      dflt_dphase <= 1'b1;
    end else if (hready) begin
      if (mapped) begin
        mux_sel     <= dec_idx;
        dflt_dphase <= 1'b0;
      end else begin
        dflt_dphase <= 1'b1;
      end
    end
  end

  // Default-slave state register
  always_ff @(posedge hclk) begin
    if (hreset) state <= D_OK;
    else        state <= state_nxt;
  end

  // Default-slave next state: two-cycle ERROR, re-armable from the completion cycle
  always_comb begin
    state_nxt = state;
    case (state)
      D_OK:    state_nxt = err_req ? D_ERR1 : D_OK;
      D_ERR1:  state_nxt = D_ERR2;
      D_ERR2:  state_nxt = err_req ? D_ERR1 : D_OK;
      default: state_nxt = D_OK;
    endcase
  end

  // Bus response: default slave when it owns the data phase, else the mux
  always_comb begin
    hready = hready_mux_in;
    hresp  = hresp_mux_in;
    if (dflt_dphase) begin
      hready = (state != D_ERR1);
      hresp  = (state == D_ERR1) || (state == D_ERR2);
    end
  end

endmodule

// File: tb/tb_ahb_addr_decoder_dphase.sv
// Self-checking bench: directed test-plan sequence with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_ahb_addr_decoder_dphase;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hready_mux_in = 1'b0;
  logic        hresp_mux_in = 1'b0;
  logic        hsel1, hsel2, hsel3, hsel4;
  logic [1:0]  mux_sel;
  logic        dflt_dphase, hready, hresp;

  int errors = 0;
  int checks = 0;

  ahb_addr_decoder_dphase dut (
    .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans),
    .hready_mux_in(hready_mux_in), .hresp_mux_in(hresp_mux_in),
    .hsel1(hsel1), .hsel2(hsel2), .hsel3(hsel3), .hsel4(hsel4),
    .mux_sel(mux_sel), .dflt_dphase(dflt_dphase), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Data-phase owner: default slave or slave index; pending default-slave
  // response beats ({hready,hresp}) queued when an unmapped active transfer
  // is accepted.
  bit         m_valid = 0;
  bit         m_dflt;
  logic [1:0] m_sel;
  logic [1:0] m_beats[$];

  function automatic logic [3:0] exp_hsel(input logic [31:0] a);
    int r = int'(a[31:28]);
    return (r < 4) ? 4'(1 << r) : 4'b0000;
  endfunction

  function automatic logic [1:0] exp_rsp();
    if (m_beats.size() != 0) return m_beats[0];
    if (m_dflt)              return 2'b10;
    return {hready_mux_in, hresp_mux_in};
  endfunction

  always @(posedge hclk) begin
    logic [1:0] rsp;
    int r;
    if (hreset) begin
      m_valid = 1; m_dflt = 1; m_sel = 2'b00; m_beats.delete();
    end else if (m_valid) begin
      rsp = exp_rsp();
      if (m_beats.size() != 0) void'(m_beats.pop_front());
      if (rsp[1]) begin
        r = int'(haddr[31:28]);
        if (r < 4) begin
          m_sel = 2'(r); m_dflt = 0;
        end else begin
          m_dflt = 1;
          if (htrans[1]) begin
            m_beats.push_back(2'b01);
            m_beats.push_back(2'b11);
          end
        end
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge
  always @(negedge hclk) begin
    logic [1:0] rsp;
    if (m_valid) begin
      rsp = exp_rsp();
      chk("m_hsel",  {28'b0, hsel4, hsel3, hsel2, hsel1}, {28'b0, exp_hsel(haddr)});
      chk("m_dflt",  {31'b0, dflt_dphase}, {31'b0, m_dflt});
      if (!m_dflt) chk("m_mux_sel", {30'b0, mux_sel}, {30'b0, m_sel});
      chk("m_hready", {31'b0, hready}, {31'b0, rsp[1]});
      chk("m_hresp",  {31'b0, hresp},  {31'b0, rsp[0]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge hclk); #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic rdy);
    haddr = a; htrans = t; hready_mux_in = rdy; #1;
  endtask

  initial begin
    // Reset with slave not ready: default slave must answer ready/OKAY
    hreset = 1; hready_mux_in = 0; hresp_mux_in = 0;
    step(); step();
    chk("rst_mux_sel", {30'b0, mux_sel}, 32'h0);
    chk("rst_dflt", {31'b0, dflt_dphase}, 32'h1);
    chk("rst_hready", {31'b0, hready}, 32'h1);
    chk("rst_hresp", {31'b0, hresp}, 32'h0);
    hreset = 0;

    // Mapped sequence
    drive(32'h1000_0040, 2'b10, 1);
    chk("dec_hsel2", {28'b0, hsel4, hsel3, hsel2, hsel1}, 32'h2);
    step();
    drive(32'h2000_0000, 2'b11, 1);
    chk("dec_hsel3", {28'b0, hsel4, hsel3, hsel2, hsel1}, 32'h4);
    chk("dp_sel_01", {30'b0, mux_sel}, 32'h1);
    step();
    drive(32'h3000_0000, 2'b10, 1);
    chk("dp_sel_10", {30'b0, mux_sel}, 32'h2);
    step();

    // Slave wait: next address ignored until the slave is ready
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_0000, 2'b10, 0);
      chk("wait_hready", {31'b0, hready}, 32'h0);
      chk("wait_sel_11", {30'b0, mux_sel}, 32'h3);
      step();
    end
    drive(32'h0000_0000, 2'b10, 1);
    chk("wait_end_sel", {30'b0, mux_sel}, 32'h3);
    step();
    chk("wait_sel_00", {30'b0, mux_sel}, 32'h0);

    // Unmapped NONSEQ: one wait ERROR cycle then completion ERROR cycle
    drive(32'h4000_0000, 2'b10, 1);
    step();
    drive(32'h0000_0000, 2'b00, 0);
    chk("err1_dflt", {31'b0, dflt_dphase}, 32'h1);
    chk("err1_rsp", {30'b0, hready, hresp}, 32'h1);
    step();
    chk("err2_rsp", {30'b0, hready, hresp}, 32'h3);
    drive(32'h8000_0000, 2'b00, 0);
    step();
    chk("err_done_rsp", {30'b0, hready, hresp}, 32'h2);

    // Unmapped IDLE: zero-wait OKAY
    step();
    chk("idle_unmapped", {30'b0, hready, hresp}, 32'h2);

    // Back-to-back unmapped NONSEQ
    drive(32'h4000_0000, 2'b10, 0);
    step();
    drive(32'h5000_0000, 2'b10, 0);
    chk("b2b_err1a", {30'b0, hready, hresp}, 32'h1);
    step();
    chk("b2b_err2a", {30'b0, hready, hresp}, 32'h3);
    step();
    drive(32'h9000_0000, 2'b00, 0);
    chk("b2b_err1b", {30'b0, hready, hresp}, 32'h1);
    step();
    chk("b2b_err2b", {30'b0, hready, hresp}, 32'h3);
    step();
    chk("b2b_done", {30'b0, hready, hresp}, 32'h2);

    // Reset mid-error aborts without an ERROR cycle
    drive(32'h6000_0000, 2'b10, 0);
    step();
    chk("pre_rst_err1", {30'b0, hready, hresp}, 32'h1);
    hreset = 1;
    step();
    hreset = 0;
    drive(32'h0000_0000, 2'b00, 0);
    chk("mid_rst_rsp", {30'b0, hready, hresp}, 32'h2);
    chk("mid_rst_sel", {30'b0, mux_sel}, 32'h0);
    chk("mid_rst_dflt", {31'b0, dflt_dphase}, 32'h1);

    // Randomized traffic, checked every cycle by the model compare
    for (int n = 0; n < 3000; n++) begin
      haddr         = {$urandom_range(0, 7) == 0 ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 5)),
                       28'($urandom)};
      htrans        = 2'($urandom_range(0, 3));
      hready_mux_in = ($urandom_range(0, 3) != 0);
      hresp_mux_in  = ($urandom_range(0, 5) == 0);
      hreset        = ($urandom_range(0, 149) == 0);
      step();
    end
    hreset = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
